// File: rtl/bus_arbiter_rr.sv
// Round-robin shared-bus arbiter with per-grant hold limit.
// One IDLE cycle between grants; forced release pulses preempt.
module bus_arbiter_rr #(
  parameter int DATA_DW  = 32,
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_DW-1:0] req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         gnt,
  output logic                     out_valid,
  output logic [DATA_DW-1:0]       out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     preempt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pre_q, pre_d;

  logic [IW-1:0]    sel;
  logic             found;
  logic             granted;
  logic             xfer;
  logic [CW-1:0]    cnt_inc;
  logic             hit_max;
  logic             rel;

  // First requester at or above ptr, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        sel   = IW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    granted   = (state_q == GRANT);
    out_valid = granted & req_valid[idx_q];
    out_last  = granted & req_last[idx_q];
    out_data  = '0;
    if (granted)
      out_data = req_data[int'(idx_q)*DATA_DW +: DATA_DW];
    req_ready = (granted && out_ready) ? gnt_q : '0;
  end

  assign gnt     = gnt_q;
  assign preempt = pre_q;

  assign xfer    = out_valid & out_ready;
  assign cnt_inc = cnt_q + CW'(1);
  assign hit_max = xfer && (cnt_inc == CW'(MAX_HOLD));
  assign rel     = (xfer && out_last) || hit_max ||
                   (!req[idx_q] && !out_valid);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = sel;
          gnt_d   = N_REQ'(1) << sel;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
          // Preempt only when the hold limit alone forced the release.
          pre_d   = hit_max && !out_last;
        end else if (xfer) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: vector tables, corner sequences,
// and a queue scoreboard for every bus transfer.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_valid, req_last, req_ready, gnt;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_last, out_ready, preempt;
  logic [DW-1:0]   out_data;

  bus_arbiter_rr #(.DATA_DW(DW), .N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] rv;
    logic [N-1:0] lst;
    logic         ordy;
    logic [N-1:0] eg;
    logic         eov;
    logic         eol;
    logic         epre;
  } vec_t;

  vec_t        t1[8];
  vec_t        t2[11];
  logic [32:0] sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          seq    = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i, input int s);
    return (32'(i) << 28) | 32'h0500_0000 | 32'(s);
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive(input string nm,
                       input logic [N-1:0] r, input logic [N-1:0] rv,
                       input logic [N-1:0] lst, input logic ordy,
                       input logic [N-1:0] eg, input logic eov,
                       input logic eol, input logic epre);
    req       = r;
    req_valid = rv;
    req_last  = lst;
    out_ready = ordy;
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = word(i, seq);
    if (eov && ordy)
      sbq.push_back({eol, word(oh2i(eg), seq)});
    @(negedge clk);
    chk({nm, ".gnt"}, 64'(gnt), 64'(eg));
    chk({nm, ".valid"}, 64'(out_valid), 64'(eov));
    chk({nm, ".last"}, 64'(out_last), 64'(eov & eol));
    chk({nm, ".preempt"}, 64'(preempt), 64'(epre));
    chk({nm, ".ready"}, 64'(req_ready), 64'(ordy ? eg : '0));
    if (eg == '0)
      chk({nm, ".data0"}, 64'(out_data), 64'(0));
    else if (eov)
      chk({nm, ".data"}, 64'(out_data), 64'(word(oh2i(eg), seq)));
    if (ordy) seq++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb: unexpected transfer data %0h", out_data);
      end else begin
        e = sbq.pop_front();
        chk("sb", 64'({out_last, out_data}), 64'(e));
      end
    end
  end

  initial begin
    t1[0] = '{4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    t1[1] = '{4'b1010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
    t1[2] = '{4'b1010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
    t1[3] = '{4'b1010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0};
    t1[4] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    t1[5] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0};
    t1[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    t1[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      logic [N-1:0] g;
      g = (i % 2 == 1 && i < 10) ? 4'(1 << (((i - 1) / 2) % 4)) : 4'b0000;
      t2[i] = '{(i < 10) ? 4'b1111 : 4'b0000, 4'b1111, 4'b1111, 1'b1,
                g, g != 0, 1'b1, 1'b0};
    end

    rst = 1'b1;
    req = '0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.gnt", 64'(gnt), 64'(0));
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.ready", 64'(req_ready), 64'(0));
    chk("rst.preempt", 64'(preempt), 64'(0));
    chk("rst.data", 64'(out_data), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      drive($sformatf("t1[%0d]", i), t1[i].req, t1[i].rv, t1[i].lst,
            t1[i].ordy, t1[i].eg, t1[i].eov, t1[i].eol, t1[i].epre);
    for (int i = 0; i < 11; i++)
      drive($sformatf("t2[%0d]", i), t2[i].req, t2[i].rv, t2[i].lst,
            t2[i].ordy, t2[i].eg, t2[i].eov, t2[i].eol, t2[i].epre);

    // Stall with req dropped while valid: grant must hold.
    drive("st0", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive("st1", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      drive($sformatf("stall%0d", i), 4'b0000, 4'b0010, 4'b0000, 1'b0,
            4'b0010, 1'b1, 1'b0, 1'b0);
    drive("st7", 4'b0000, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
    drive("st8", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Requester 2 streams without last: hold limit forces release.
    drive("pr0", 4'b1100, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= MH; i++)
      drive($sformatf("pr%0d", i), 4'b1100, 4'b0100, 4'b0000, 1'b1,
            4'b0100, 1'b1, 1'b0, 1'b0);
    drive("pr17", 4'b1100, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    drive("pr18", 4'b1100, 4'b0100, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    drive("dr0", 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    drive("dr1", 4'b1001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive("dr2", 4'b1001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);

    // Reset mid-burst on requester 1.
    drive("rs0", 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive("rs1", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rsa.gnt", 64'(gnt), 64'(0));
    chk("rsa.valid", 64'(out_valid), 64'(0));
    chk("rsa.ready", 64'(req_ready), 64'(0));
    chk("rsa.data", 64'(out_data), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive("rs2", 4'b0011, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive("rs3", 4'b0011, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive("rs4", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive("rs5", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
